pc_seq_ras: RTL and testbench
=============================

Name: pc_seq_ras

Overview:
- Parametrised successor to the core program counter. Adds:
  - relative branches;
  - call/return through a hardware return-address stack (RAS);
  - a pipeline stall.
- Sits in the fetch stage. Drives the instruction-memory address. Takes branch-op and condition from decode/ALU.
- All state updates occur on the rising clk edge.

Parameters:
- D, 12, program-counter and target width in bits.
- OFS_W, 8, width of the signed relative-branch offset (OFS_W <= D).
- RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- br_op  input  3  branch operation, encoding per pc_pkg::br_op_t.
- jcnd  input  1  branch condition from ALU.
- target  input  D  absolute jump/call destination.
- offset  input  OFS_W  signed relative displacement.
- prog_ctr  output  D  current program counter.
- ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_ovf  output  1  sticky: push onto full stack occurred.
- ras_unf  output  1  sticky: pop from empty stack occurred.
- halted  output  1  halt state (see Optional Feature).

Behaviour:
- Reset values: prog_ctr=0, ras_count=0, ras_ovf=0, ras_unf=0, halted=0. RAS contents are don't-care.
- Priority order: reset > stall > halted > br_op.
- stall=1: prog_ctr, RAS, count and flags all hold. br_op is ignored, so no push or pop happens.
- br_op encodings (3'bxxx):
  - 000 NOP: pc+1.
  - 001 JMP: target.
  - 010 BT: target if jcnd, else pc+1.
  - 011 BF: target if !jcnd, else pc+1.
  - 100 RBT: pc+sext(offset) if jcnd, else pc+1.
  - 101 CALL: push pc+1, then pc=target.
  - 110 RET: pop, pc=popped value.
  - 111 HALT: see Optional Feature.
- Arithmetic: all modulo 2^D. Wrap-around is silent: D'hFFF+1 -> 0, and 0+sext(-1) -> D'hFFF.
- offset is sign-extended to D bits. An offset of 0 on a taken branch holds pc.
- RAS is circular: write pointer wp, ras_count saturates at RAS_DEPTH.
  - Push: entry[wp]=value, wp++.
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH, ras_ovf<=1.
  - Pop: wp--, return entry[wp-1], count--.
  - Pop when empty (count=0): pc=pc+1, wp and count unchanged, ras_unf<=1.
- Sticky flags clear only on reset.
- Reset mid-call/return sequence: the stack is logically emptied in one cycle (count=0, wp=0).
- Single-cycle latency: prog_ctr reflects the br_op of the previous non-stalled cycle.

Optional Feature:
- Macro: PC_SEQ_HALT_EN.
- Defined:
  - br_op=111 sets halted<=1 and holds prog_ctr.
  - While halted, br_op is ignored and the RAS is frozen.
  - Only reset clears halted.
- Undefined:
  - br_op=111 behaves as NOP (pc+1).
  - halted is tied to 0.

Decomposition:
- Package pc_pkg:
  - br_op_t enum (NOP, JMP, BT, BF, RBT, CALL, RET, HALT);
  - default widths as localparams.
- Sub-module pc_ras: circular stack with push/pop/value inputs and count/ovf/unf outputs, parameterised by D and RAS_DEPTH.
- The top-level module holds the next-pc mux and the halt logic.

Test Plan:
- Reset, then 3 NOPs -> prog_ctr 0,1,2,3. Reset asserted while prog_ctr=5 -> 0 next cycle, ras_count=0.
- Condition combinations:
  - JMP target=0x100 -> pc=0x100.
  - BT jcnd=0 -> 0x101.
  - BF jcnd=0 target=0x200 -> 0x200.
  - RBT from pc=0x200, jcnd=1, offset=-4 (8'hFC) -> 0x1FC.
  - RBT from pc=0x001, offset=-2 -> 0xFFF.
- Nested calls, RAS_DEPTH=4:
  - CALL from pc 0x10 -> 0x40, then CALL from 0x40 -> 0x80.
  - RET -> 0x41, RET -> 0x11, ras_count returns to 0, no flags.
- Overflow:
  - 5 CALLs from pcs 0,10,20,30,40 (target=pc+10) -> ras_ovf=1, count=4.
  - 4 RETs -> 41,31,21,11.
  - 5th RET -> pc+1, ras_unf=1.
- stall=1 held 3 cycles with br_op=CALL -> prog_ctr, ras_count unchanged. Release -> the CALL executes once.
- PC_SEQ_HALT_EN defined:
  - HALT at pc=0x20 -> halted=1, pc stays 0x20 for 5 cycles despite JMP.
  - reset clears halted.
  - Macro undefined: HALT -> pc 0x21, halted=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default widths for the sequencing program counter.
package pc_pkg;

  localparam int unsigned PC_D_DEF         = 12;
  localparam int unsigned PC_OFS_W_DEF     = 8;
  localparam int unsigned PC_RAS_DEPTH_DEF = 4;

  // Branch operation presented by decode each cycle.
  typedef enum logic [2:0] {
    NOP  = 3'b000,
    JMP  = 3'b001,
    BT   = 3'b010,
    BF   = 3'b011,
    RBT  = 3'b100,
    CALL = 3'b101,
    RET  = 3'b110,
    HALT = 3'b111
  } br_op_t;

endpackage

// File: rtl/pc_ras.sv
// Circular hardware return-address stack with saturating count and sticky
// overflow/underflow flags. push and pop are expected to be mutually exclusive.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned D         = PC_D_DEF,
  parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [D-1:0]                 push_val,
  output logic [D-1:0]                 pop_val_c,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         ovf,
  output logic                         unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [D-1:0]  mem [RAS_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] wp_dec;
  logic          full;
  logic          empty;

  assign wp_dec    = wp - PW'(1);
  assign full      = (count == CW'(RAS_DEPTH));
  assign empty     = (count == '0);
  assign pop_val_c = mem[wp_dec];

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= push_val;
    end
  end

  // Pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      wp <= wp + PW'(1);
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wp    <= wp_dec;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_seq_ras.sv
// Fetch-stage program counter with absolute/relative branches, call/return
// through a return-address stack, and a pipeline stall.
// Optional halt support is enabled by defining PC_SEQ_HALT_EN.
module pc_seq_ras
  import pc_pkg::*;
#(
  parameter int unsigned D         = PC_D_DEF,
  parameter int unsigned OFS_W     = PC_OFS_W_DEF,
  parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic [2:0]                   br_op,
  input  logic                         jcnd,
  input  logic [D-1:0]                 target,
  input  logic [OFS_W-1:0]             offset,
  output logic [D-1:0]                 prog_ctr,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_ovf,
  output logic                         ras_unf,
  output logic                         halted
);

  br_op_t                  op;
  logic                    advance_c;
  logic signed [OFS_W-1:0] ofs_s;
  logic [D-1:0]            ofs_ext;
  logic [D-1:0]            pc_inc;
  logic [D-1:0]            pc_nxt;
  logic [D-1:0]            pop_val_c;
  logic                    push;
  logic                    pop;

  assign op        = br_op_t'(br_op);
  assign ofs_s     = offset;
  assign ofs_ext   = D'(ofs_s);
  assign pc_inc    = prog_ctr + D'(1);
  assign advance_c = !reset && !stall && !halted;

  // Next-pc selection and stack requests for the current branch op.
  always_comb begin
    pc_nxt = prog_ctr;
    push   = 1'b0;
    pop    = 1'b0;
    if (advance_c) begin
      pc_nxt = pc_inc;
      case (op)
        NOP: ;
        JMP: pc_nxt = target;
        BT:  if (jcnd) pc_nxt = target;
        BF:  if (!jcnd) pc_nxt = target;
        RBT: if (jcnd) pc_nxt = prog_ctr + ofs_ext;
        CALL: begin
          push   = 1'b1;
          pc_nxt = target;
        end
        RET: begin
          pop = 1'b1;
          if (ras_count != '0) pc_nxt = pop_val_c;
        end
`ifdef PC_SEQ_HALT_EN
        HALT: pc_nxt = prog_ctr;
`else
        HALT: ;
`endif
        default: ;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr <= '0;
    end else begin
      prog_ctr <= pc_nxt;
    end
  end

`ifdef PC_SEQ_HALT_EN
  // Halt latch; only reset releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (advance_c && (op == HALT)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  pc_ras #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_val  (pc_inc),
    .pop_val_c (pop_val_c),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_seq_ras.sv
// Scoreboard bench for pc_seq_ras: the driver queues hand-computed results,
// a monitor compares them after each clock edge.
module tb_pc_seq_ras;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic        jcnd = 1'b0;
  logic [11:0] target = '0;
  logic [7:0]  offset = '0;
  logic [11:0] prog_ctr;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;
  logic        halted;

  typedef struct {
    string       nm;
    logic [11:0] pc;
    int          cnt;
    logic        ovf;
    logic        unf;
    logic        hlt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pc_seq_ras #(.D(12), .OFS_W(8), .RAS_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_op     (br_op),
    .jcnd      (jcnd),
    .target    (target),
    .offset    (offset),
    .prog_ctr  (prog_ctr),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry is consumed per edge that follows a driven cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if (prog_ctr === e.pc && int'(ras_count) == e.cnt && ras_ovf === e.ovf &&
          ras_unf === e.unf && halted === e.hlt) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b halt=%b, want pc=%h cnt=%0d ovf=%b unf=%b halt=%b",
                 e.nm, prog_ctr, ras_count, ras_ovf, ras_unf, halted,
                 e.pc, e.cnt, e.ovf, e.unf, e.hlt);
      end
    end
  end

  task automatic step(input string nm, input logic rs, input logic st,
                      input logic [2:0] op, input logic jc,
                      input logic [11:0] tg, input logic [7:0] of,
                      input logic [11:0] epc, input int ecnt,
                      input logic eo, input logic eu, input logic eh);
    exp_t e;
    @(negedge clk);
    reset  = rs;
    stall  = st;
    br_op  = op;
    jcnd   = jc;
    target = tg;
    offset = of;
    e.nm = nm; e.pc = epc; e.cnt = ecnt; e.ovf = eo; e.unf = eu; e.hlt = eh;
    q.push_back(e);
  endtask

  initial begin
    logic        hen;
    logic [11:0] hpc;
    int          hcnt;
`ifdef PC_SEQ_HALT_EN
    hen = 1'b1;
`else
    hen = 1'b0;
`endif

    // Reset and sequential fetch, then reset in the middle of a call.
    step("reset",      1, 0, NOP,  0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0);
    step("nop1",       0, 0, NOP,  0, 12'h000, 8'h00, 12'h001, 0, 0, 0, 0);
    step("nop2",       0, 0, NOP,  0, 12'h000, 8'h00, 12'h002, 0, 0, 0, 0);
    step("nop3",       0, 0, NOP,  0, 12'h000, 8'h00, 12'h003, 0, 0, 0, 0);
    step("call_to5",   0, 0, CALL, 0, 12'h005, 8'h00, 12'h005, 1, 0, 0, 0);
    step("reset_mid",  1, 0, RET,  0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0);

    // Conditional and relative branches, including wrap-around.
    step("jmp100",     0, 0, JMP,  0, 12'h100, 8'h00, 12'h100, 0, 0, 0, 0);
    step("bt_nt",      0, 0, BT,   0, 12'h300, 8'h00, 12'h101, 0, 0, 0, 0);
    step("bf_t",       0, 0, BF,   0, 12'h200, 8'h00, 12'h200, 0, 0, 0, 0);
    step("rbt_m4",     0, 0, RBT,  1, 12'h000, 8'hFC, 12'h1FC, 0, 0, 0, 0);
    step("rbt_nt",     0, 0, RBT,  0, 12'h000, 8'hFC, 12'h1FD, 0, 0, 0, 0);
    step("rbt_zero",   0, 0, RBT,  1, 12'h000, 8'h00, 12'h1FD, 0, 0, 0, 0);
    step("rbt_p3",     0, 0, RBT,  1, 12'h000, 8'h03, 12'h200, 0, 0, 0, 0);
    step("bt_t",       0, 0, BT,   1, 12'h001, 8'h00, 12'h001, 0, 0, 0, 0);
    step("rbt_wrap",   0, 0, RBT,  1, 12'h000, 8'hFE, 12'hFFF, 0, 0, 0, 0);
    step("nop_wrap",   0, 0, NOP,  0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0);
    step("bf_nt",      0, 0, BF,   1, 12'h123, 8'h00, 12'h001, 0, 0, 0, 0);

    // Nested calls and returns.
    step("jmp10",      0, 0, JMP,  0, 12'h010, 8'h00, 12'h010, 0, 0, 0, 0);
    step("call40",     0, 0, CALL, 0, 12'h040, 8'h00, 12'h040, 1, 0, 0, 0);
    step("call80",     0, 0, CALL, 0, 12'h080, 8'h00, 12'h080, 2, 0, 0, 0);
    step("ret41",      0, 0, RET,  0, 12'h000, 8'h00, 12'h041, 1, 0, 0, 0);
    step("ret11",      0, 0, RET,  0, 12'h000, 8'h00, 12'h011, 0, 0, 0, 0);

    // Overflow then underflow.
    step("jmp0",       0, 0, JMP,  0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0);
    step("ocall1",     0, 0, CALL, 0, 12'h010, 8'h00, 12'h010, 1, 0, 0, 0);
    step("ocall2",     0, 0, CALL, 0, 12'h020, 8'h00, 12'h020, 2, 0, 0, 0);
    step("ocall3",     0, 0, CALL, 0, 12'h030, 8'h00, 12'h030, 3, 0, 0, 0);
    step("ocall4",     0, 0, CALL, 0, 12'h040, 8'h00, 12'h040, 4, 0, 0, 0);
    step("ocall5_ovf", 0, 0, CALL, 0, 12'h050, 8'h00, 12'h050, 4, 1, 0, 0);
    step("oret41",     0, 0, RET,  0, 12'h000, 8'h00, 12'h041, 3, 1, 0, 0);
    step("oret31",     0, 0, RET,  0, 12'h000, 8'h00, 12'h031, 2, 1, 0, 0);
    step("oret21",     0, 0, RET,  0, 12'h000, 8'h00, 12'h021, 1, 1, 0, 0);
    step("oret11",     0, 0, RET,  0, 12'h000, 8'h00, 12'h011, 0, 1, 0, 0);
    step("oret_unf",   0, 0, RET,  0, 12'h000, 8'h00, 12'h012, 0, 1, 1, 0);
    step("sticky",     0, 0, NOP,  0, 12'h000, 8'h00, 12'h013, 0, 1, 1, 0);
    step("reset_flag", 1, 0, NOP,  0, 12'h000, 8'h00, 12'h000, 0, 0, 0, 0);

    // Stall holds everything; the pending CALL executes once on release.
    step("jmp30",      0, 0, JMP,  0, 12'h030, 8'h00, 12'h030, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step("stall_call", 0, 1, CALL, 0, 12'h070, 8'h00, 12'h030, 0, 0, 0, 0);
    step("rel_call",   0, 0, CALL, 0, 12'h070, 8'h00, 12'h070, 1, 0, 0, 0);
    step("after_call", 0, 0, NOP,  0, 12'h000, 8'h00, 12'h071, 1, 0, 0, 0);
    step("ret_once",   0, 0, RET,  0, 12'h000, 8'h00, 12'h031, 0, 0, 0, 0);

    // Halt: freezes pc and stack when enabled, acts as NOP otherwise.
    step("jmp20",      0, 0, JMP,  0, 12'h020, 8'h00, 12'h020, 0, 0, 0, 0);
    step("halt",       0, 0, HALT, 0, 12'h000, 8'h00, hen ? 12'h020 : 12'h021, 0, 0, 0, hen);
    hpc  = hen ? 12'h020 : 12'h100;
    hcnt = hen ? 0 : 1;
    step("halt_call",  0, 0, CALL, 0, 12'h100, 8'h00, hpc, hcnt, 0, 0, hen);
    for (int i = 0; i < 4; i++)
      step("halt_jmp", 0, 0, JMP,  0, 12'h100, 8'h00, hpc, hcnt, 0, 0, hen);
    step("reset_stl",  1, 1, JMP,  0, 12'h100, 8'h00, 12'h000, 0, 0, 0, 0);
    step("post_reset", 0, 0, NOP,  0, 12'h000, 8'h00, 12'h001, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
